// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the 8-bit CPU.
// Owns pc, ir, acc and operand registers, drives the external ALU and runs a
// shared memory through a ready handshake.
// Optional feature macro: SEQ_RESUME_EN. When it is defined, resume_i leaves HALT.
// When it is undefined, HALT is left only by reset.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | after reset, no strobes, goes straight to fetch
// S_FETCH  | read instruction at pc, load ir and bump pc on ready
// S_DECODE | dispatch on opcode; SKZ and JMP finish here
// S_OPREAD | read operand at ir address into opnd on ready
// S_EXEC   | latch ALU result into acc
// S_STORE  | write acc to ir address, done on ready
// S_HALT   | frozen, halted_o high

module cpu_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] alu_rs1_o,
    output logic [DATA_W-1:0] alu_rs2_o,
    output logic [2:0]        alu_opcode_o,
    input  logic [DATA_W-1:0] alu_rd_i,
    input  logic              alu_is_zero_i,
    input  logic              resume_i,
    output logic              halted_o,
    output logic [ADDR_W-1:0] pc_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPREAD = 3'd3,
        S_EXEC   = 3'd4,
        S_STORE  = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;

    logic [2:0]        ir_op;
    logic [ADDR_W-1:0] ir_addr;
    logic              leave_halt;

    assign ir_op   = ir_q[DATA_W-1 -: 3];
    assign ir_addr = ir_q[ADDR_W-1:0];

`ifdef SEQ_RESUME_EN
    assign leave_halt = resume_i;
`else
    // resume has no effect in this build; keep the port for a uniform pinout
    logic unused_resume;
    assign unused_resume = resume_i;
    assign leave_halt    = 1'b0;
`endif

    // State and datapath registers; reset discards any in-flight access
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (ir_op)
                    OP_HLT:                         state_d = S_HALT;
                    OP_SKZ, OP_JMP:                 state_d = S_FETCH;
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: state_d = S_OPREAD;
                    OP_STO:                         state_d = S_STORE;
                    default:                        state_d = S_HALT;
                endcase
            end
            S_OPREAD: if (mem_ready_i) state_d = S_EXEC;
            S_EXEC:   state_d = S_FETCH;
            S_STORE:  if (mem_ready_i) state_d = S_FETCH;
            S_HALT:   if (leave_halt) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath register updates; pc wraps naturally at 2^ADDR_W
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) begin
                    ir_d = mem_rdata_i;
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            S_DECODE: begin
                if (ir_op == OP_SKZ && alu_is_zero_i) pc_d = pc_q + ADDR_W'(1);
                if (ir_op == OP_JMP)                  pc_d = ir_addr;
            end
            S_OPREAD: if (mem_ready_i) opnd_d = mem_rdata_i;
            S_EXEC:   acc_d = alu_rd_i;
            default: ;
        endcase
    end

    // Output decode; strobes come from state only so rd and wr are exclusive
    always_comb begin
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        mem_addr_o = '0;
        halted_o   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = pc_q;
            end
            S_OPREAD: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = ir_addr;
            end
            S_STORE: begin
                mem_wr_o   = 1'b1;
                mem_addr_o = ir_addr;
            end
            S_HALT: halted_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_wdata_o  = acc_q;
    assign alu_rs1_o    = acc_q;
    assign alu_rs2_o    = opnd_q;
    assign alu_opcode_o = ir_op;
    assign pc_o         = pc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer with a behavioural ALU and 32x8 memory.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst_n;
    logic [4:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic [7:0] alu_rs1;
    logic [7:0] alu_rs2;
    logic [2:0] alu_opcode;
    logic [7:0] alu_rd;
    logic       alu_is_zero;
    logic       resume;
    logic       halted;
    logic [4:0] pc;

    logic [7:0] mem [32];

    int n_checks = 0;
    int n_errors = 0;

    cpu_sequencer #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .mem_addr_o    (mem_addr),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_ready_i   (mem_ready),
        .alu_rs1_o     (alu_rs1),
        .alu_rs2_o     (alu_rs2),
        .alu_opcode_o  (alu_opcode),
        .alu_rd_i      (alu_rd),
        .alu_is_zero_i (alu_is_zero),
        .resume_i      (resume),
        .halted_o      (halted),
        .pc_o          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        alu_rd = alu_rs1;
        case (alu_opcode)
            3'd2: alu_rd = alu_rs1 + alu_rs2;
            3'd3: alu_rd = alu_rs1 & alu_rs2;
            3'd4: alu_rd = alu_rs1 ^ alu_rs2;
            3'd5: alu_rd = alu_rs2;
            default: alu_rd = alu_rs1;
        endcase
    end
    assign alu_is_zero = (alu_rs1 == 8'h00);

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr && mem_ready) mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Enter reset, clear memory; caller loads the program before release
    task automatic enter_reset();
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        resume    = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    // Release mid-cycle; the next step() lands in cycle 1 (FETCH)
    task automatic release_reset();
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(output int cycles);
        cycles = 0;
        while (!halted && cycles < 200) begin
            step();
            cycles++;
        end
        check("halt_reached", 32'(halted), 1);
    endtask

    int cyc;

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        resume    = 1'b0;

        // Reset state
        enter_reset();
        #3;
        check("rst_mem_rd",     32'(mem_rd),     0);
        check("rst_mem_wr",     32'(mem_wr),     0);
        check("rst_mem_addr",   32'(mem_addr),   0);
        check("rst_mem_wdata",  32'(mem_wdata),  0);
        check("rst_alu_rs1",    32'(alu_rs1),    0);
        check("rst_alu_rs2",    32'(alu_rs2),    0);
        check("rst_alu_opcode", 32'(alu_opcode), 0);
        check("rst_halted",     32'(halted),     0);
        check("rst_pc",         32'(pc),         0);

        // LDA 20, ADD 21, STO 22, HLT
        mem[0]  = 8'hB4;
        mem[1]  = 8'h55;
        mem[2]  = 8'hD6;
        mem[3]  = 8'h00;
        mem[20] = 8'h05;
        mem[21] = 8'hFE;
        release_reset();
        step();
        check("chain_fetch_rd",   32'(mem_rd),   1);
        check("chain_fetch_addr", 32'(mem_addr), 0);
        cyc = 1;
        while (!halted && cyc < 200) begin
            step();
            cyc++;
        end
        check("chain_cycles",  32'(cyc),       14);
        check("chain_mem22",   32'(mem[22]),   32'h03);
        check("chain_halted",  32'(halted),    1);
        check("chain_pc",      32'(pc),        4);
        check("chain_acc",     32'(alu_rs1),   32'h03);
        check("chain_wdata",   32'(mem_wdata), 32'h03);
        check("halt_no_rd",    32'(mem_rd),    0);
        check("halt_no_wr",    32'(mem_wr),    0);
        check("halt_addr0",    32'(mem_addr),  0);

        // SKZ taken: acc = 0 at SKZ on pc 3
        enter_reset();
        mem[0] = 8'hB4; mem[1] = 8'hB4; mem[2] = 8'hB4;
        mem[3] = 8'h20; mem[4] = 8'h00; mem[5] = 8'h00;
        mem[20] = 8'h00;
        release_reset();
        steps(13);
        check("skz0_fetch_addr", 32'(mem_addr), 3);
        steps(2);
        check("skz0_next_rd",   32'(mem_rd),   1);
        check("skz0_next_addr", 32'(mem_addr), 5);
        run_to_halt(cyc);
        check("skz0_pc", 32'(pc), 6);

        // SKZ not taken: acc = 1
        enter_reset();
        mem[0] = 8'hB4; mem[1] = 8'hB4; mem[2] = 8'hB4;
        mem[3] = 8'h20; mem[4] = 8'h00; mem[5] = 8'h00;
        mem[20] = 8'h01;
        release_reset();
        steps(15);
        check("skz1_next_addr", 32'(mem_addr), 4);
        run_to_halt(cyc);
        check("skz1_pc", 32'(pc), 5);

        // JMP 31, LDA at 31, then wrap to 0
        enter_reset();
        mem[0]  = 8'h20;
        mem[1]  = 8'h00;
        mem[2]  = 8'hFF;
        mem[31] = 8'hB4;
        mem[20] = 8'h42;
        release_reset();
        steps(5);
        check("jmp_fetch31_addr", 32'(mem_addr), 31);
        check("jmp_fetch31_rd",   32'(mem_rd),   1);
        steps(4);
        check("wrap_fetch_addr", 32'(mem_addr), 0);
        check("wrap_pc",         32'(pc),       0);
        run_to_halt(cyc);
        check("jmp_final_pc",  32'(pc),      2);
        check("jmp_final_acc", 32'(alu_rs1), 32'h42);

        // Three wait states during OPREAD of ADD
        enter_reset();
        mem[0] = 8'hB4;
        mem[1] = 8'h55;
        mem[2] = 8'h00;
        mem[20] = 8'h10;
        mem[21] = 8'h25;
        release_reset();
        steps(6);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_rd",   32'(mem_rd),   1);
            check("wait_addr", 32'(mem_addr), 21);
        end
        step();
        check("wait_last_rd",   32'(mem_rd),   1);
        check("wait_last_addr", 32'(mem_addr), 21);
        mem_ready = 1'b1;
        step();
        check("wait_exec_no_rd", 32'(mem_rd), 0);
        step();
        check("wait_next_fetch_rd",   32'(mem_rd),   1);
        check("wait_next_fetch_addr", 32'(mem_addr), 2);
        check("wait_acc",             32'(alu_rs1),  32'h35);

        // Reset mid-STORE while memory stalls
        enter_reset();
        mem[0]  = 8'hD6;
        mem[22] = 8'hAA;
        release_reset();
        steps(2);
        mem_ready = 1'b0;
        step();
        check("sto_wr",   32'(mem_wr),   1);
        check("sto_addr", 32'(mem_addr), 22);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("sto_rst_wr_drop", 32'(mem_wr),   0);
        check("sto_rst_addr",    32'(mem_addr), 0);
        steps(2);
        check("sto_no_write", 32'(mem[22]), 32'hAA);
        mem_ready = 1'b1;
        release_reset();
        step();
        check("sto_restart_rd",   32'(mem_rd),   1);
        check("sto_restart_addr", 32'(mem_addr), 0);
        check("sto_restart_pc",   32'(pc),       0);

        // HALT then resume pulse
        enter_reset();
        mem[0]  = 8'h00;
        mem[1]  = 8'hB4;
        mem[2]  = 8'h00;
        mem[20] = 8'h77;
        release_reset();
        run_to_halt(cyc);
        check("hlt_first_pc", 32'(pc), 1);
        steps(3);
        check("hlt_frozen_halted", 32'(halted), 1);
        check("hlt_frozen_pc",     32'(pc),     1);
        resume = 1'b1;
        step();
        resume = 1'b0;
`ifdef SEQ_RESUME_EN
        check("resume_fetch_rd",   32'(mem_rd),   1);
        check("resume_fetch_addr", 32'(mem_addr), 1);
        steps(10);
        check("resume_halted", 32'(halted),  1);
        check("resume_pc",     32'(pc),      3);
        check("resume_acc",    32'(alu_rs1), 32'h77);
`else
        check("noresume_rd", 32'(mem_rd), 0);
        steps(10);
        check("noresume_halted", 32'(halted),  1);
        check("noresume_pc",     32'(pc),      1);
        check("noresume_acc",    32'(alu_rs1), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

- Multi-cycle fetch/decode/execute controller for the 8-bit CPU.
- Sits directly upstream of the ALU:
  - Owns the program counter, instruction register, accumulator and operand register.
  - Drives the ALU's `rs1`, `rs2` and `opcode`, consumes its `rd` and `is_zero`.
  - Sequences a shared 32×8 memory through a ready-handshake port.

## Interface
Parameters:
- `ADDR_W`, 5: memory address width; instruction address field is `ir[ADDR_W-1:0]`.
- `DATA_W`, 8: data, accumulator and instruction width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rd`  out  1  read strobe, held until `mem_ready`.
- `mem_wr`  out  1  write strobe, held until `mem_ready`.
- `mem_wdata`  out  DATA_W  write data (= accumulator).
- `mem_rdata`  in  DATA_W  read data, valid in the cycle `mem_ready`=1.
- `mem_ready`  in  1  memory completes current access this cycle.
- `alu_rs1`  out  DATA_W  = accumulator.
- `alu_rs2`  out  DATA_W  = operand register.
- `alu_opcode`  out  3  = `ir[7:5]`.
- `alu_rd`  in  DATA_W  ALU result.
- `alu_is_zero`  in  1  ALU flag, accumulator == 0.
- `resume`  in  1  leave HALT (used only under `SEQ_RESUME_EN`).
- `halted`  out  1  high in HALT.
- `pc`  out  ADDR_W  current program counter (debug).

## Operation
- Instruction format: `[7:5]` opcode, `[4:0]` address. Opcodes:
  - 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- States: IDLE, FETCH, DECODE, OPREAD, EXEC, STORE, HALT.
- IDLE: reset state, no strobes. Goes to FETCH next cycle.
- FETCH: `mem_addr`=pc, `mem_rd`=1. On `mem_ready`: ir<=`mem_rdata`, pc<=pc+1, go to DECODE.
- DECODE:
  - HLT: go to HALT.
  - SKZ: if `alu_is_zero`, pc<=pc+1. Go to FETCH.
  - JMP: pc<=ir[4:0]. Go to FETCH.
  - ADD/AND/XOR/LDA: go to OPREAD.
  - STO: go to STORE.
- OPREAD: `mem_addr`=ir[4:0], `mem_rd`=1. On `mem_ready`: opnd<=`mem_rdata`, go to EXEC.
- EXEC: acc<=`alu_rd`, go to FETCH. The ALU computes acc+opnd, acc&opnd, acc^opnd, or opnd (LDA).
- STORE: `mem_addr`=ir[4:0], `mem_wr`=1, `mem_wdata`=acc. On `mem_ready`, go to FETCH.
- HALT: `halted`=1, no strobes. Registers are frozen.
- `mem_rd` and `mem_wr` are decoded combinationally from state and are never both high.
- `mem_addr` is 0 outside FETCH/OPREAD/STORE.
- PC arithmetic is modulo 2^ADDR_W:
  - pc 31 fetch gives pc=0.
  - SKZ at pc 30 (pc=31 after fetch) skips to 0.
- Accumulator arithmetic is modulo 2^DATA_W; there is no carry out.

## Timing
- Reset values: pc=0, ir=0, acc=0, opnd=0, state=IDLE.
  - Outputs: `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `alu_rs1`=0, `alu_rs2`=0, `alu_opcode`=0, `halted`=0, `pc`=0.
- Reset is asynchronous. Assertion mid-access drops strobes in the same cycle and discards the access.
- Zero-wait latency (`mem_ready` always 1), cycles from FETCH entry to next FETCH:
  - HLT: 2 to reach HALT.
  - SKZ, JMP: 2.
  - STO: 3.
  - ADD, AND, XOR, LDA: 4.
- Each memory wait cycle adds one cycle. The strobe and address stay stable throughout.
- `alu_is_zero` is sampled in DECODE and reflects acc as written by the previous instruction.
- Acc updates at the end of EXEC; the new value is visible on `alu_rs1`/`mem_wdata` the next cycle.

## Configuration
- `SEQ_RESUME_EN`:
  - Defined: `resume`=1 in HALT returns to FETCH next cycle. pc is unchanged, already pointing past HLT.
  - Undefined: `resume` is ignored, and HALT is left only by reset.

## Test plan
- LDA/ADD chain: mem[20]=0x05, mem[21]=0xFE; program LDA 20, ADD 21, STO 22, HLT.
  - Expect mem[22]=0x03, `halted`=1, total 4+4+3+2=13 cycles after IDLE.
- SKZ both ways:
  - acc=0 at pc 3 (SKZ): next fetch at pc 5.
  - acc=0x01: next fetch at pc 4.
- JMP 0x1F, then instruction at 31 executes.
  - A following non-jump fetch wraps to pc 0.
- Wait states: `mem_ready` low 3 cycles during OPREAD of an ADD.
  - `mem_rd` and `mem_addr` held stable; instruction takes 7 cycles; acc correct.
- Reset asserted mid-STORE with `mem_ready`=0: `mem_wr` drops immediately, no write occurs, and after release fetch restarts at pc 0.
- HALT then `resume` pulse:
  - With `SEQ_RESUME_EN`, fetch resumes at the address after HLT.
  - Without it, the sequencer stays halted.
